jtag_uart_access_sched: RTL and testbench
=========================================

// Module: jtag_uart_access_sched
// PURPOSE
//  Sole Avalon master for the JTAG UART slave. Shares the slave between an RX byte stream (polling the
//  DATA register) and a TX byte source (writes gated by WSPACE read from the CONTROL register).
//  Schedules accesses so neither direction starves. Sits between the JTAG UART core and the decode/parse path.
// PARAMETERS
//  MAX_RX_BURST     8   max consecutive valid RX reads before a pending TX gets the slave (1..255)
//  RX_IDLE_BACKOFF  16  idle cycles after an RX read returns RVALID=0 before the next RX poll (0 = none)
// PORTS
//  iCLK               in   1   clock, all logic on posedge
//  iRST               in   1   reset, synchronous, active-high
//  oJTAG_SLAVE_ADDR   out  1   0=DATA reg, 1=CONTROL reg
//  oJTAG_SLAVE_RDREQ  out  1   Avalon read
//  iJTAG_SLAVE_RDDATA in   32  Avalon readdata
//  oJTAG_SLAVE_WRREQ  out  1   Avalon write
//  oJTAG_SLAVE_WRDATA out  32  Avalon writedata, {24'd0, byte}
//  iJTAG_SLAVE_WAIT   in   1   Avalon waitrequest
//  iRX_EN             in   1   1 = RX polling enabled
//  oRX_DATA           out  8   received byte
//  oRX_VALID          out  1   1-cycle strobe, oRX_DATA valid
//  iTX_DATA           in   8   byte to send
//  iTX_VALID          in   1   TX byte offered
//  oTX_READY          out  1   byte accepted on cycle iTX_VALID&oTX_READY
//  oBUSY              out  1   FSM not in ST_IDLE
//  oRX_BYTES/oTX_BYTES out 16  byte counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=ST_IDLE; ADDR/RDREQ/WRREQ=0, WRDATA=0, oRX_VALID=0, oRX_DATA=0, oTX_READY=0, TX holding reg
//   empty, wspace credit=0, burst cnt=0, backoff cnt=0. Reset mid-transfer abandons it; no byte emitted.
//  TX holding reg: 1 byte. oTX_READY=~full (registered). Filled on handshake; emptied when its write completes.
//  Avalon: request held (ADDR/RDREQ/WRREQ/WRDATA stable) until WAIT=0 sampled; access completes that cycle.
//   RDDATA sampled on cycle after completion (latency 1).
//  States: ST_IDLE, ST_RD_DATA, ST_RD_DATA_LAT, ST_RD_CTRL, ST_RD_CTRL_LAT, ST_WR_DATA.
//  ST_IDLE pick (priority): TX full & credit>0 & (burst cnt==MAX_RX_BURST | no RX eligible) -> ST_WR_DATA;
//   TX full & credit==0 & same condition -> ST_RD_CTRL; RX eligible (iRX_EN & backoff==0) -> ST_RD_DATA;
//   else stay. Request asserted the cycle after entering the state.
//  ST_RD_DATA_LAT: RDDATA[15]=1 -> oRX_DATA=RDDATA[7:0], oRX_VALID=1 that cycle+1, burst cnt+1 (saturating);
//   RDDATA[15]=0 -> backoff=RX_IDLE_BACKOFF, burst cnt=0. -> ST_IDLE.
//  ST_RD_CTRL_LAT: credit=RDDATA[31:16] (WSPACE, 16b). -> ST_IDLE. If WSPACE=0, next TX attempt re-reads CTRL
//   only after one RX poll opportunity (if RX eligible), preventing CONTROL spin from blocking RX.
//  ST_WR_DATA complete: credit-1, TX reg emptied, burst cnt=0 -> ST_IDLE.
//  Burst cnt reaching MAX_RX_BURST forces TX slot only when TX full; else RX continues, cnt saturates.
//  Backoff counts down 1/cycle in any state; iRX_EN=0 blocks new RX reads but in-flight read completes.
//  Simultaneous TX handshake and TX write completion: impossible (READY=0 while full).
// CONFIGURATION
//  JTAG_SCHED_STATS_EN defined: oRX_BYTES +1 per oRX_VALID, oTX_BYTES +1 per completed write; 16b wrap
//   0xFFFF->0; cleared by iRST. Undefined: both ports constant 0, no counter flops.
// TESTING
//  1 RX only: iRX_EN=1, slave returns 0x00008041 after WAIT=1 for 2 cycles -> oRX_VALID 1 cycle, oRX_DATA=0x41.
//  2 Empty RX: RDDATA[15]=0, RX_IDLE_BACKOFF=16 -> next RDREQ no earlier than 16 cycles later; no oRX_VALID.
//  3 TX credit: iTX_DATA=0x5A, CTRL returns 0x00400000 -> one CTRL read, then write WRDATA=0x0000005A;
//    next 63 bytes written with no further CTRL read; 65th byte triggers CTRL read.
//  4 Fairness: RX always valid, TX byte pending, MAX_RX_BURST=8 -> exactly 8 RX reads between TX writes.
//  5 WSPACE=0: CTRL returns 0x00000000 -> no WRREQ; RX reads interleave between CTRL polls; write follows first
//    nonzero WSPACE.
//  6 Reset: assert iRST while WAIT=1 during RD_DATA -> next cycle RDREQ=0, oBUSY=0, no oRX_VALID; counters=0.

Source files
------------

// File: rtl/jtag_uart_access_sched.sv
// Sole Avalon master for the JTAG UART: shares the slave between RX polling and gated TX writes.
// Optional byte statistics are built when JTAG_SCHED_STATS_EN is defined.
module jtag_uart_access_sched #(
  parameter int MAX_RX_BURST    = 8,
  parameter int RX_IDLE_BACKOFF = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  input  logic        iRX_EN,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic [7:0]  iTX_DATA,
  input  logic        iTX_VALID,
  output logic        oTX_READY,
  output logic        oBUSY,
  output logic [15:0] oRX_BYTES,
  output logic [15:0] oTX_BYTES
);

  localparam int BOFF_W = (RX_IDLE_BACKOFF > 0) ? $clog2(RX_IDLE_BACKOFF + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DATA,
    ST_RD_DATA_LAT,
    ST_RD_CTRL,
    ST_RD_CTRL_LAT,
    ST_WR_DATA
  } state_t;

  state_t              state;
  logic                txFull;
  logic [7:0]          txByte;
  logic [15:0]         credit;
  logic [7:0]          burstCnt;
  logic [BOFF_W-1:0]   backoff;
  logic                ctrlBlock;

  logic rxEligible, burstMax, txSlot, txHandshake, rxAccept, wrDone;

  assign rxEligible  = iRX_EN && (backoff == '0);
  assign burstMax    = (burstCnt == 8'(MAX_RX_BURST));
  assign txSlot      = txFull && (burstMax || !rxEligible);
  assign txHandshake = iTX_VALID && oTX_READY;
  assign rxAccept    = (state == ST_RD_DATA_LAT) && iJTAG_SLAVE_RDDATA[15];
  assign wrDone      = (state == ST_WR_DATA) && !iJTAG_SLAVE_WAIT;
  assign oBUSY       = (state != ST_IDLE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state              <= ST_IDLE;
      oJTAG_SLAVE_ADDR   <= 1'b0;
      oJTAG_SLAVE_RDREQ  <= 1'b0;
      oJTAG_SLAVE_WRREQ  <= 1'b0;
      oJTAG_SLAVE_WRDATA <= '0;
      oRX_DATA           <= '0;
      oRX_VALID          <= 1'b0;
      oTX_READY          <= 1'b0;
      txFull             <= 1'b0;
      txByte             <= '0;
      credit             <= '0;
      burstCnt           <= '0;
      backoff            <= '0;
      ctrlBlock          <= 1'b0;
    end else begin
      oRX_VALID <= 1'b0;
      if (backoff != '0) backoff <= backoff - 1'b1;

      if (txHandshake) begin
        txFull    <= 1'b1;
        txByte    <= iTX_DATA;
        oTX_READY <= 1'b0;
      end else begin
        oTX_READY <= !txFull;
      end

      // NOTE: later non-blocking assignments in this block override the defaults above (e.g. backoff reload, TX release).
      unique case (state)
        ST_IDLE: begin
          if (txSlot && credit != '0) begin
            state              <= ST_WR_DATA;
            oJTAG_SLAVE_ADDR   <= 1'b0;
            oJTAG_SLAVE_WRREQ  <= 1'b1;
            oJTAG_SLAVE_WRDATA <= {24'd0, txByte};
          end else if (txSlot && !(ctrlBlock && rxEligible)) begin
            state             <= ST_RD_CTRL;
            oJTAG_SLAVE_ADDR  <= 1'b1;
            oJTAG_SLAVE_RDREQ <= 1'b1;
          end else if (rxEligible) begin
            state             <= ST_RD_DATA;
            oJTAG_SLAVE_ADDR  <= 1'b0;
            oJTAG_SLAVE_RDREQ <= 1'b1;
            ctrlBlock         <= 1'b0;
          end
        end
        ST_RD_DATA: if (!iJTAG_SLAVE_WAIT) begin
          oJTAG_SLAVE_RDREQ <= 1'b0;
          state             <= ST_RD_DATA_LAT;
        end
        ST_RD_DATA_LAT: begin
          if (rxAccept) begin
            oRX_DATA  <= iJTAG_SLAVE_RDDATA[7:0];
            oRX_VALID <= 1'b1;
            if (!burstMax) burstCnt <= burstCnt + 1'b1;
          end else begin
            backoff  <= BOFF_W'(RX_IDLE_BACKOFF);
            burstCnt <= '0;
          end
          state <= ST_IDLE;
        end
        ST_RD_CTRL: if (!iJTAG_SLAVE_WAIT) begin
          oJTAG_SLAVE_RDREQ <= 1'b0;
          state             <= ST_RD_CTRL_LAT;
        end
        ST_RD_CTRL_LAT: begin
          // A zero WSPACE yields one RX poll before CONTROL is read again.
          credit    <= iJTAG_SLAVE_RDDATA[31:16];
          ctrlBlock <= (iJTAG_SLAVE_RDDATA[31:16] == 16'd0);
          state     <= ST_IDLE;
        end
        ST_WR_DATA: if (wrDone) begin
          oJTAG_SLAVE_WRREQ <= 1'b0;
          credit            <= credit - 1'b1;
          txFull            <= 1'b0;
          oTX_READY         <= 1'b1;
          burstCnt          <= '0;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JTAG_SCHED_STATS_EN
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oRX_BYTES <= '0;
      oTX_BYTES <= '0;
    end else begin
      if (rxAccept) oRX_BYTES <= oRX_BYTES + 1'b1;
      if (wrDone)   oTX_BYTES <= oTX_BYTES + 1'b1;
    end
  end
`else
  assign oRX_BYTES = '0;
  assign oTX_BYTES = '0;
`endif

endmodule

// File: tb/tb_jtag_uart_access_sched.sv
// Directed bench for jtag_uart_access_sched with a behavioural Avalon slave that logs every access.
module tb_jtag_uart_access_sched;

`ifdef JTAG_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ;
  logic [31:0] iJTAG_SLAVE_RDDATA = '0;
  logic [31:0] oJTAG_SLAVE_WRDATA;
  logic        iJTAG_SLAVE_WAIT = 1'b0;
  logic        iRX_EN = 1'b0;
  logic [7:0]  oRX_DATA;
  logic        oRX_VALID;
  logic [7:0]  iTX_DATA = '0;
  logic        iTX_VALID = 1'b0;
  logic        oTX_READY, oBUSY;
  logic [15:0] oRX_BYTES, oTX_BYTES;

  jtag_uart_access_sched #(.MAX_RX_BURST(8), .RX_IDLE_BACKOFF(16)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oJTAG_SLAVE_ADDR(oJTAG_SLAVE_ADDR), .oJTAG_SLAVE_RDREQ(oJTAG_SLAVE_RDREQ),
    .iJTAG_SLAVE_RDDATA(iJTAG_SLAVE_RDDATA), .oJTAG_SLAVE_WRREQ(oJTAG_SLAVE_WRREQ),
    .oJTAG_SLAVE_WRDATA(oJTAG_SLAVE_WRDATA), .iJTAG_SLAVE_WAIT(iJTAG_SLAVE_WAIT),
    .iRX_EN(iRX_EN), .oRX_DATA(oRX_DATA), .oRX_VALID(oRX_VALID),
    .iTX_DATA(iTX_DATA), .iTX_VALID(iTX_VALID), .oTX_READY(oTX_READY),
    .oBUSY(oBUSY), .oRX_BYTES(oRX_BYTES), .oTX_BYTES(oTX_BYTES)
  );

  always #5 iCLK = ~iCLK;

  int passCnt = 0;
  int totalCnt = 0;

  // Slave configuration, written by the test tasks only.
  int          waitCfg = 0;
  logic [31:0] dataResp = '0;
  logic [31:0] ctrlDefault = '0;
  logic [31:0] ctrlQ[$];

  // Slave-owned state and logs.
  logic [7:0]  seqLog[$];
  logic [31:0] wrLog[$];
  logic [7:0]  rxQ[$];
  int          rxValidNeg[$];
  int          reqStart[$];
  int          negCnt = 0, waitCnt = 0, curHigh = 0, lastHigh = 0, lastCompleteNeg = 0, stabErr = 0;
  logic        pending = 1'b0, respPending = 1'b0;
  logic [31:0] respVal = '0;
  logic [34:0] prevBus = '0;

  always @(negedge iCLK) begin
    negCnt = negCnt + 1;
    if (respPending) begin
      iJTAG_SLAVE_RDDATA = respVal;
      respPending = 1'b0;
    end else begin
      iJTAG_SLAVE_RDDATA = 32'hFFFF_FFFF;
    end
    if (oRX_VALID) begin
      rxQ.push_back(oRX_DATA);
      rxValidNeg.push_back(negCnt);
    end
    if (oJTAG_SLAVE_RDREQ && oJTAG_SLAVE_WRREQ) stabErr = stabErr + 1;
    if (oJTAG_SLAVE_RDREQ || oJTAG_SLAVE_WRREQ) begin
      if (!pending) begin
        reqStart.push_back(negCnt);
        curHigh = 0;
      end else if ({oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA} != prevBus) begin
        stabErr = stabErr + 1;
      end
      curHigh = curHigh + 1;
      if (waitCnt < waitCfg) begin
        iJTAG_SLAVE_WAIT = 1'b1;
        waitCnt = waitCnt + 1;
        pending = 1'b1;
      end else begin
        iJTAG_SLAVE_WAIT = 1'b0;
        waitCnt = 0;
        pending = 1'b0;
        lastHigh = curHigh;
        lastCompleteNeg = negCnt;
        if (oJTAG_SLAVE_WRREQ) begin
          seqLog.push_back("W");
          wrLog.push_back(oJTAG_SLAVE_WRDATA);
        end else if (oJTAG_SLAVE_ADDR) begin
          seqLog.push_back("C");
          respVal = (ctrlQ.size() > 0) ? ctrlQ.pop_front() : ctrlDefault;
          respPending = 1'b1;
        end else begin
          seqLog.push_back("R");
          respVal = dataResp;
          respPending = 1'b1;
        end
      end
    end else begin
      iJTAG_SLAVE_WAIT = 1'b0;
      waitCnt = 0;
      pending = 1'b0;
    end
    prevBus = {oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge iCLK);
    #1;
  endtask

  function automatic int countIn(logic [7:0] c, int from, int upTo);
    int n = 0;
    for (int i = from; i < upTo && i < seqLog.size(); i++) if (seqLog[i] == c) n++;
    return n;
  endfunction

  function automatic int nthIdx(logic [7:0] c, int nth, int from);
    int n = 0;
    for (int i = from; i < seqLog.size(); i++) begin
      if (seqLog[i] == c) begin
        if (n == nth) return i;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic resetDut();
    iRST = 1'b1;
    iRX_EN = 1'b0;
    iTX_VALID = 1'b0;
    repeat (2) tick();
    iRST = 1'b0;
    tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    int t = 0;
    while (oTX_READY !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    totalCnt++;
    if (oTX_READY !== 1'b1) $display("FAIL tx_ready_wait got=%b want=1 byte=%h", oTX_READY, b);
    else passCnt++;
    iTX_DATA = b;
    iTX_VALID = 1'b1;
    tick();
    iTX_VALID = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) tick();
    totalCnt++; if (oJTAG_SLAVE_RDREQ !== 1'b0) $display("FAIL reset_rdreq got=%b want=0", oJTAG_SLAVE_RDREQ); else passCnt++;
    totalCnt++; if (oJTAG_SLAVE_WRREQ !== 1'b0) $display("FAIL reset_wrreq got=%b want=0", oJTAG_SLAVE_WRREQ); else passCnt++;
    totalCnt++; if (oJTAG_SLAVE_ADDR !== 1'b0) $display("FAIL reset_addr got=%b want=0", oJTAG_SLAVE_ADDR); else passCnt++;
    totalCnt++; if (oJTAG_SLAVE_WRDATA !== 32'h0) $display("FAIL reset_wrdata got=%h want=0", oJTAG_SLAVE_WRDATA); else passCnt++;
    totalCnt++; if (oRX_VALID !== 1'b0) $display("FAIL reset_rx_valid got=%b want=0", oRX_VALID); else passCnt++;
    totalCnt++; if (oRX_DATA !== 8'h00) $display("FAIL reset_rx_data got=%h want=00", oRX_DATA); else passCnt++;
    totalCnt++; if (oTX_READY !== 1'b0) $display("FAIL reset_tx_ready got=%b want=0", oTX_READY); else passCnt++;
    totalCnt++; if (oBUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", oBUSY); else passCnt++;
    totalCnt++; if (oRX_BYTES !== 16'd0 || oTX_BYTES !== 16'd0) $display("FAIL reset_counters got=%0d/%0d want=0/0", oRX_BYTES, oTX_BYTES); else passCnt++;
    iRST = 1'b0;
    repeat (2) tick();
    totalCnt++; if (oTX_READY !== 1'b1) $display("FAIL post_reset_tx_ready got=%b want=1", oTX_READY); else passCnt++;
    totalCnt++; if (seqLog.size() !== 0) $display("FAIL post_reset_idle accesses=%0d want=0", seqLog.size()); else passCnt++;
  endtask

  task automatic test_rx_single();
    int sBase = seqLog.size();
    int rBase = rxQ.size();
    logic [7:0] got;
    int lat;
    waitCfg = 2;
    dataResp = 32'h0000_8041;
    iRX_EN = 1'b1;
    tick();
    iRX_EN = 1'b0;
    repeat (15) tick();
    got = (rxQ.size() > rBase) ? rxQ[rBase] : 8'h00;
    lat = (rxValidNeg.size() > rBase) ? rxValidNeg[rBase] - lastCompleteNeg : -1;
    totalCnt++; if (countIn("R", sBase, seqLog.size()) !== 1) $display("FAIL rx1_reads got=%0d want=1", countIn("R", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (rxQ.size() - rBase !== 1) $display("FAIL rx1_valid_pulses got=%0d want=1", rxQ.size() - rBase); else passCnt++;
    totalCnt++; if (got !== 8'h41) $display("FAIL rx1_data got=%h want=41", got); else passCnt++;
    totalCnt++; if (lastHigh !== 3) $display("FAIL rx1_req_held got=%0d want=3 cycles", lastHigh); else passCnt++;
    totalCnt++; if (lat !== 2) $display("FAIL rx1_valid_latency got=%0d want=2", lat); else passCnt++;
    totalCnt++; if (oBUSY !== 1'b0) $display("FAIL rx1_idle_busy got=%b want=0", oBUSY); else passCnt++;
  endtask

  task automatic test_rx_empty();
    int sBase = seqLog.size();
    int qBase = reqStart.size();
    int rBase = rxQ.size();
    int gap, frozen, t;
    waitCfg = 0;
    dataResp = 32'h0000_0000;
    iRX_EN = 1'b1;
    t = 0;
    while (reqStart.size() - qBase < 2 && t < 80) begin
      tick();
      t++;
    end
    iRX_EN = 1'b0;
    gap = (reqStart.size() - qBase >= 2) ? reqStart[qBase + 1] - reqStart[qBase] : -1;
    totalCnt++; if (reqStart.size() - qBase < 2) $display("FAIL rx_empty_polls got=%0d want>=2", reqStart.size() - qBase); else passCnt++;
    totalCnt++; if (gap < 16 || gap > 24) $display("FAIL rx_empty_backoff_gap got=%0d want 16..24", gap); else passCnt++;
    repeat (3) tick();
    frozen = seqLog.size();
    repeat (40) tick();
    totalCnt++; if (seqLog.size() !== frozen) $display("FAIL rx_disabled_reads got=%0d want=%0d", seqLog.size(), frozen); else passCnt++;
    totalCnt++; if (rxQ.size() !== rBase) $display("FAIL rx_empty_valid got=%0d want=%0d", rxQ.size(), rBase); else passCnt++;
    totalCnt++; if (countIn("W", sBase, seqLog.size()) + countIn("C", sBase, seqLog.size()) !== 0) $display("FAIL rx_empty_tx_access got=%0d want=0", countIn("W", sBase, seqLog.size()) + countIn("C", sBase, seqLog.size())); else passCnt++;
  endtask

  task automatic test_tx_credit();
    int sBase, wBase, t, bad, c2;
    resetDut();
    sBase = seqLog.size();
    wBase = wrLog.size();
    waitCfg = 1;
    ctrlDefault = 32'h0040_0000;
    for (int i = 0; i < 65; i++) sendByte((i == 0) ? 8'h5A : 8'(i));
    t = 0;
    while (wrLog.size() - wBase < 65 && t < 200) begin
      tick();
      t++;
    end
    bad = 0;
    for (int i = 0; i < 65; i++) begin
      if (wBase + i >= wrLog.size() || wrLog[wBase + i] !== {24'd0, ((i == 0) ? 8'h5A : 8'(i))}) bad++;
    end
    c2 = nthIdx("C", 1, sBase);
    totalCnt++; if (wrLog.size() - wBase !== 65) $display("FAIL tx_write_count got=%0d want=65", wrLog.size() - wBase); else passCnt++;
    totalCnt++; if (seqLog.size() <= sBase || seqLog[sBase] !== "C") $display("FAIL tx_first_ctrl got=%0d want=first access CTRL", nthIdx("C", 0, sBase) - sBase); else passCnt++;
    totalCnt++; if (countIn("C", sBase, seqLog.size()) !== 2) $display("FAIL tx_ctrl_reads got=%0d want=2", countIn("C", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (c2 - sBase !== 65) $display("FAIL tx_second_ctrl_pos got=%0d want=65", c2 - sBase); else passCnt++;
    totalCnt++; if (wrLog.size() <= wBase || wrLog[wBase] !== 32'h0000_005A) $display("FAIL tx_first_wrdata got=%h want=0000005a", (wrLog.size() > wBase) ? wrLog[wBase] : 32'hx); else passCnt++;
    totalCnt++; if (bad !== 0) $display("FAIL tx_wrdata_stream got=%0d bad words want=0", bad); else passCnt++;
    totalCnt++; if (stabErr !== 0) $display("FAIL bus_stable_under_wait got=%0d violations want=0", stabErr); else passCnt++;
    totalCnt++; if (oTX_BYTES !== (STATS ? 16'd65 : 16'd0)) $display("FAIL tx_byte_counter got=%0d want=%0d", oTX_BYTES, STATS ? 65 : 0); else passCnt++;
    totalCnt++; if (oRX_BYTES !== 16'd0) $display("FAIL tx_rx_counter got=%0d want=0", oRX_BYTES); else passCnt++;
  endtask

  task automatic test_fairness();
    int sBase, wBase, rBase, t, w0, w1, w2, badData;
    resetDut();
    sBase = seqLog.size();
    wBase = wrLog.size();
    rBase = rxQ.size();
    waitCfg = 0;
    dataResp = 32'h0000_8033;
    ctrlDefault = 32'h0040_0000;
    iRX_EN = 1'b1;
    sendByte(8'hA1);
    sendByte(8'hA2);
    sendByte(8'hA3);
    t = 0;
    while (wrLog.size() - wBase < 3 && t < 200) begin
      tick();
      t++;
    end
    iRX_EN = 1'b0;
    repeat (5) tick();
    w0 = nthIdx("W", 0, sBase);
    w1 = nthIdx("W", 1, sBase);
    w2 = nthIdx("W", 2, sBase);
    badData = 0;
    for (int i = rBase; i < rxQ.size(); i++) if (rxQ[i] !== 8'h33) badData++;
    totalCnt++; if (w2 < 0) $display("FAIL fair_writes got=%0d want=3", wrLog.size() - wBase); else passCnt++;
    totalCnt++; if (countIn("R", w0 + 1, w1) !== 8 || w1 < 0) $display("FAIL fair_gap1_reads got=%0d want=8", countIn("R", w0 + 1, w1)); else passCnt++;
    totalCnt++; if (countIn("R", w1 + 1, w2) !== 8 || w2 < 0) $display("FAIL fair_gap2_reads got=%0d want=8", countIn("R", w1 + 1, w2)); else passCnt++;
    totalCnt++; if (countIn("C", sBase, seqLog.size()) !== 1) $display("FAIL fair_ctrl_reads got=%0d want=1", countIn("C", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (rxQ.size() - rBase !== countIn("R", sBase, seqLog.size())) $display("FAIL fair_rx_bytes got=%0d want=%0d", rxQ.size() - rBase, countIn("R", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (badData !== 0) $display("FAIL fair_rx_data got=%0d bad bytes want=0", badData); else passCnt++;
    totalCnt++; if (wrLog.size() - wBase < 3 || wrLog[wBase + 2] !== 32'h0000_00A3) $display("FAIL fair_last_wrdata got=%h want=000000a3", (wrLog.size() - wBase >= 3) ? wrLog[wBase + 2] : 32'hx); else passCnt++;
    totalCnt++; if (oRX_BYTES !== (STATS ? 16'(rxQ.size() - rBase) : 16'd0)) $display("FAIL fair_rx_counter got=%0d want=%0d", oRX_BYTES, STATS ? rxQ.size() - rBase : 0); else passCnt++;
  endtask

  task automatic test_wspace_zero();
    int sBase, wBase, t, c0, c1, c2, w0;
    resetDut();
    sBase = seqLog.size();
    wBase = wrLog.size();
    waitCfg = 0;
    dataResp = 32'h0000_8055;
    ctrlQ.push_back(32'h0000_0000);
    ctrlQ.push_back(32'h0000_0000);
    ctrlDefault = 32'h0002_0000;
    iRX_EN = 1'b1;
    sendByte(8'h77);
    t = 0;
    while (wrLog.size() - wBase < 1 && t < 300) begin
      tick();
      t++;
    end
    iRX_EN = 1'b0;
    repeat (5) tick();
    c0 = nthIdx("C", 0, sBase);
    c1 = nthIdx("C", 1, sBase);
    c2 = nthIdx("C", 2, sBase);
    w0 = nthIdx("W", 0, sBase);
    totalCnt++; if (countIn("C", sBase, seqLog.size()) !== 3) $display("FAIL ws0_ctrl_reads got=%0d want=3", countIn("C", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (countIn("W", sBase, seqLog.size()) !== 1) $display("FAIL ws0_writes got=%0d want=1", countIn("W", sBase, seqLog.size())); else passCnt++;
    totalCnt++; if (c1 < 0 || countIn("R", c0 + 1, c1) < 1) $display("FAIL ws0_rx_between_1 got=%0d want>=1", countIn("R", c0 + 1, c1)); else passCnt++;
    totalCnt++; if (c2 < 0 || countIn("R", c1 + 1, c2) < 1) $display("FAIL ws0_rx_between_2 got=%0d want>=1", countIn("R", c1 + 1, c2)); else passCnt++;
    totalCnt++; if (c2 < 0 || w0 !== c2 + 1) $display("FAIL ws0_write_after_credit got=%0d want=%0d", w0 - sBase, c2 + 1 - sBase); else passCnt++;
    totalCnt++; if (wrLog.size() <= wBase || wrLog[wBase] !== 32'h0000_0077) $display("FAIL ws0_wrdata got=%h want=00000077", (wrLog.size() > wBase) ? wrLog[wBase] : 32'hx); else passCnt++;
  endtask

  task automatic test_reset_midway();
    int rBase, t;
    resetDut();
    rBase = rxQ.size();
    waitCfg = 1000;
    dataResp = 32'h0000_8099;
    iRX_EN = 1'b1;
    t = 0;
    while (oJTAG_SLAVE_RDREQ !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    totalCnt++; if (oJTAG_SLAVE_RDREQ !== 1'b1) $display("FAIL midrst_rdreq_start got=%b want=1", oJTAG_SLAVE_RDREQ); else passCnt++;
    repeat (2) tick();
    iRST = 1'b1;
    tick();
    totalCnt++; if (oJTAG_SLAVE_RDREQ !== 1'b0) $display("FAIL midrst_rdreq got=%b want=0", oJTAG_SLAVE_RDREQ); else passCnt++;
    totalCnt++; if (oBUSY !== 1'b0) $display("FAIL midrst_busy got=%b want=0", oBUSY); else passCnt++;
    totalCnt++; if (oRX_VALID !== 1'b0) $display("FAIL midrst_rx_valid got=%b want=0", oRX_VALID); else passCnt++;
    iRST = 1'b0;
    iRX_EN = 1'b0;
    waitCfg = 0;
    repeat (10) tick();
    totalCnt++; if (rxQ.size() !== rBase) $display("FAIL midrst_no_byte got=%0d want=%0d", rxQ.size(), rBase); else passCnt++;
    totalCnt++; if (oRX_BYTES !== 16'd0 || oTX_BYTES !== 16'd0) $display("FAIL midrst_counters got=%0d/%0d want=0/0", oRX_BYTES, oTX_BYTES); else passCnt++;
    totalCnt++; if (stabErr !== 0) $display("FAIL bus_stable_final got=%0d violations want=0", stabErr); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_empty();
    test_tx_credit();
    test_fairness();
    test_wspace_zero();
    test_reset_midway();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
